// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - scan control, mux select/sense and sample handshake bundle
//
// Purpose: groups every non-clock signal of mux_scan_sequencer.
//   start, abort, channel_mask : scan control from the requester
//   address0, address1, mux_out: select lines to / sensed bit from the 4:1 mux
//   busy                       : scan in progress
//   valid, ready, sample       : 4-bit result handed downstream
// Modports: master = sequencer side, slave = environment side.
interface mux_scan_sequencer_if;
   logic       start;
   logic       abort;
   logic [3:0] channel_mask;
   logic       mux_out;
   logic       address0;
   logic       address1;
   logic       busy;
   logic       valid;
   logic       ready;
   logic [3:0] sample;

   modport master (
      input  start, abort, channel_mask, mux_out, ready,
      output address0, address1, busy, valid, sample
   );

   modport slave (
      output start, abort, channel_mask, mux_out, ready,
      input  address0, address1, busy, valid, sample
   );
endinterface

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - scans a 4:1 gate-level mux into a clocked 4-bit sample
//
// Purpose: steps the mux select lines through the enabled channels in
// ascending order, holds each address SETTLE_CYCLES clocks, samples mux_out,
// then offers the assembled 4-bit vector on a valid/ready handshake.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mux_scan_sequencer_if.master (control, mux select/sense, result)
// Parameters:
//   SETTLE_CYCLES : clocks each address is held before sampling (1..15)
//   ADDR_SWAP     : 0 -> address1 = ch[1], address0 = ch[0]; 1 -> swapped
module mux_scan_sequencer #(
   parameter int SETTLE_CYCLES = 4,
   parameter bit ADDR_SWAP     = 1'b0
) (
   input logic                  clk,
   input logic                  rst_n,
   mux_scan_sequencer_if.master bus
);

   localparam logic [3:0] LP_RELOAD = 4'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_next_state;
   logic [3:0] r_mask;
   logic [1:0] r_ch;
   logic [3:0] r_cnt;
   logic [3:0] r_sample;
   logic [1:0] r_addr;       // [1] = address1, [0] = address0
   logic [1:0] w_first_ch;
   logic       w_first_any;
   logic [1:0] w_next_ch;
   logic       w_has_next;
   logic       w_busy;
   logic       w_valid;

   // Channel number to select-line pair, honouring the netlist wiring order.
   function automatic logic [1:0] f_addr(input logic [1:0] ch);
      if (ADDR_SWAP)
         f_addr = {ch[0], ch[1]};
      else
         f_addr = ch;
   endfunction

   // Lowest enabled channel of the incoming mask, and the next enabled
   // channel above the current one. Descending loops so the lowest wins.
   always_comb begin
      w_first_ch  = 2'd0;
      w_first_any = 1'b0;
      w_next_ch   = 2'd0;
      w_has_next  = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (bus.channel_mask[i]) begin
            w_first_ch  = 2'(i);
            w_first_any = 1'b1;
         end
         if (r_mask[i] && (i > int'(r_ch))) begin
            w_next_ch  = 2'(i);
            w_has_next = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   // Next-state logic; abort outranks the capture decision in SETTLE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.start)
               w_next_state = w_first_any ? ST_SETTLE : ST_DONE;
         end
         ST_SETTLE: begin
            if (bus.abort)
               w_next_state = ST_IDLE;
            else if ((r_cnt == 4'd0) && !w_has_next)
               w_next_state = ST_DONE;
         end
         ST_DONE: begin
            if (bus.ready)
               w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Outputs decode from the state register only.
   always_comb begin
      w_busy  = (r_state == ST_SETTLE);
      w_valid = (r_state == ST_DONE);
   end

   // Datapath: mask/channel/counter, captured bits and select lines.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mask   <= 4'd0;
         r_ch     <= 2'd0;
         r_cnt    <= 4'd0;
         r_sample <= 4'd0;
         r_addr   <= 2'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_mask   <= bus.channel_mask;
                  r_sample <= 4'd0;
                  if (w_first_any) begin
                     r_ch   <= w_first_ch;
                     r_addr <= f_addr(w_first_ch);
                     r_cnt  <= LP_RELOAD;
                  end
               end
            end
            ST_SETTLE: begin
               if (!bus.abort) begin
                  if (r_cnt != 4'd0) begin
                     r_cnt <= r_cnt - 4'd1;
                  end else begin
                     r_sample[r_ch] <= bus.mux_out;
                     // Next address goes out on the capture edge itself so
                     // its settle window starts immediately.
                     if (w_has_next) begin
                        r_ch   <= w_next_ch;
                        r_addr <= f_addr(w_next_ch);
                        r_cnt  <= LP_RELOAD;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.address0 = r_addr[0];
   assign bus.address1 = r_addr[1];
   assign bus.busy     = w_busy;
   assign bus.valid    = w_valid;
   assign bus.sample   = r_sample;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - self-checking bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] start_v = 3'b000;
   logic       abort = 1'b0;
   logic       ready = 1'b0;
   logic [3:0] mask = 4'd0;
   logic [3:0] in_v = 4'd0;

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Instance 0: S=4 normal order; 1: S=2 normal order; 2: S=1 swapped order.
   mux_scan_sequencer_if if_a ();
   mux_scan_sequencer_if if_b ();
   mux_scan_sequencer_if if_c ();

   assign if_a.start = start_v[0];
   assign if_b.start = start_v[1];
   assign if_c.start = start_v[2];
   assign if_a.abort = abort;
   assign if_b.abort = abort;
   assign if_c.abort = abort;
   assign if_a.ready = ready;
   assign if_b.ready = ready;
   assign if_c.ready = ready;
   assign if_a.channel_mask = mask;
   assign if_b.channel_mask = mask;
   assign if_c.channel_mask = mask;
   // Behavioural 4:1 mux per instance, wired as each netlist would be.
   assign if_a.mux_out = in_v[{if_a.address1, if_a.address0}];
   assign if_b.mux_out = in_v[{if_b.address1, if_b.address0}];
   assign if_c.mux_out = in_v[{if_c.address0, if_c.address1}];

   mux_scan_sequencer #(.SETTLE_CYCLES(4), .ADDR_SWAP(1'b0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   mux_scan_sequencer #(.SETTLE_CYCLES(2), .ADDR_SWAP(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   mux_scan_sequencer #(.SETTLE_CYCLES(1), .ADDR_SWAP(1'b1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   function automatic logic get_valid(input int i);
      case (i)
         0: get_valid = if_a.valid;
         1: get_valid = if_b.valid;
         default: get_valid = if_c.valid;
      endcase
   endfunction

   function automatic logic get_busy(input int i);
      case (i)
         0: get_busy = if_a.busy;
         1: get_busy = if_b.busy;
         default: get_busy = if_c.busy;
      endcase
   endfunction

   function automatic logic [3:0] get_sample(input int i);
      case (i)
         0: get_sample = if_a.sample;
         1: get_sample = if_b.sample;
         default: get_sample = if_c.sample;
      endcase
   endfunction

   // Raw select lines {address1, address0}
   function automatic logic [1:0] get_addr(input int i);
      case (i)
         0: get_addr = {if_a.address1, if_a.address0};
         1: get_addr = {if_b.address1, if_b.address0};
         default: get_addr = {if_c.address1, if_c.address0};
      endcase
   endfunction

   // Channel selected, decoded with the wiring order of that instance.
   function automatic logic [1:0] chan_of(input int i);
      logic [1:0] a;
      a = get_addr(i);
      chan_of = (i == 2) ? {a[0], a[1]} : a;
   endfunction

   // {address1, address0, busy, valid, sample}
   function automatic logic [7:0] all_outs(input int i);
      all_outs = {get_addr(i), get_busy(i), get_valid(i), get_sample(i)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Start high for exactly one edge E; returns at the negedge after E.
   task automatic pulse_start(input int i);
      @(negedge clk);
      start_v = 3'b000;
      start_v[i] = 1'b1;
      cycle();
      start_v = 3'b000;
   endtask

   task automatic wait_valid(input int i, output int n);
      n = 0;
      while (!get_valid(i) && n < 200) begin
         cycle();
         n++;
      end
      if (n >= 200) check("valid_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      int         inst;
      logic [3:0] vmask;
      logic [3:0] vins;
      logic [3:0] exp_sample;
      int         exp_lat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int lat;
      int busy_cnt;
      int n;
      int bad;
      logic [3:0] seen;

      //              inst  mask     in3..0   sample   edges to valid
      vecs[0] = '{0, 4'b1111, 4'b1101, 4'b1101, 16};
      vecs[1] = '{1, 4'b1010, 4'b0010, 4'b0010, 4};
      vecs[2] = '{0, 4'b0000, 4'b1111, 4'b0000, 0};
      vecs[3] = '{2, 4'b0100, 4'b0100, 4'b0100, 1};
      vecs[4] = '{2, 4'b1111, 4'b0110, 4'b0110, 4};
      vecs[5] = '{1, 4'b1001, 4'b1111, 4'b1001, 4};
      vecs[6] = '{0, 4'b0110, 4'b1001, 4'b0000, 8};

      repeat (3) cycle();
      for (int i = 0; i < 3; i++) check($sformatf("reset_outs_%0d", i), 32'(all_outs(i)), 32'd0);
      rst_n = 1'b1;
      cycle();

      for (int v = 0; v < 7; v++) begin
         mask = vecs[v].vmask;
         in_v = vecs[v].vins;
         pulse_start(vecs[v].inst);
         lat = 0;
         busy_cnt = 0;
         seen = 4'd0;
         while (!get_valid(vecs[v].inst) && lat < 100) begin
            if (get_busy(vecs[v].inst)) begin
               busy_cnt++;
               seen[chan_of(vecs[v].inst)] = 1'b1;
            end
            cycle();
            lat++;
         end
         check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
         check($sformatf("v%0d_busy_cycles", v), 32'(busy_cnt), 32'(vecs[v].exp_lat));
         check($sformatf("v%0d_addressed", v), 32'(seen), 32'(vecs[v].vmask));
         check($sformatf("v%0d_sample", v), 32'(get_sample(vecs[v].inst)), 32'(vecs[v].exp_sample));
         ready = 1'b1;
         cycle();
         ready = 1'b0;
         check($sformatf("v%0d_valid_after_ready", v), 32'(get_valid(vecs[v].inst)), 32'd0);
         check($sformatf("v%0d_sample_hold", v), 32'(get_sample(vecs[v].inst)), 32'(vecs[v].exp_sample));
      end

      // Abort at E+6 with a stray start at E+2; partial sample stays, no rescan.
      mask = 4'b1111;
      in_v = 4'b1111;
      pulse_start(0);
      for (int j = 1; j <= 6; j++) begin
         start_v[0] = (j == 2);
         abort = (j == 6);
         cycle();
      end
      start_v = 3'b000;
      abort = 1'b0;
      check("abort_busy", 32'(get_busy(0)), 32'd0);
      check("abort_valid", 32'(get_valid(0)), 32'd0);
      check("abort_partial_sample", 32'(get_sample(0)), 32'b0001);
      bad = 0;
      for (int j = 0; j < 20; j++) begin
         if (get_busy(0) || get_valid(0)) bad++;
         cycle();
      end
      check("abort_no_rescan", 32'(bad), 32'd0);

      // Abort on the capture edge wins over the capture.
      pulse_start(0);
      for (int j = 1; j <= 4; j++) begin
         abort = (j == 4);
         cycle();
      end
      abort = 1'b0;
      check("abort_at_capture_sample", 32'(get_sample(0)), 32'd0);
      check("abort_at_capture_busy", 32'(get_busy(0)), 32'd0);

      // Reset in SETTLE after the first capture.
      pulse_start(0);
      for (int j = 1; j <= 6; j++) begin
         rst_n = (j != 6);
         cycle();
      end
      rst_n = 1'b1;
      check("reset_in_settle", 32'(all_outs(0)), 32'd0);

      // DONE held with ready low, then start+ready together.
      mask = 4'b0011;
      in_v = 4'b0011;
      pulse_start(0);
      wait_valid(0, n);
      for (int j = 0; j < 10; j++) begin
         check($sformatf("hold_%0d", j), 32'({get_valid(0), get_sample(0)}), 32'b1_0011);
         cycle();
      end
      start_v[0] = 1'b1;
      ready = 1'b1;
      cycle();
      start_v = 3'b000;
      ready = 1'b0;
      check("start_ready_valid", 32'(get_valid(0)), 32'd0);
      check("start_ready_busy", 32'(get_busy(0)), 32'd0);
      cycle();
      check("start_ready_no_scan", 32'({get_busy(0), get_valid(0)}), 32'd0);

      // Reset in DONE with a non-zero address and sample.
      mask = 4'b1000;
      in_v = 4'b1000;
      pulse_start(0);
      wait_valid(0, n);
      check("pre_reset_done", 32'(all_outs(0)), 32'b1101_1000);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      check("reset_in_done", 32'(all_outs(0)), 32'd0);
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
